// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins and deserialises
// 11-bit frames into scan codes, with parity, stop-bit and inter-bit timeout checks.
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_clk_q, filt_clk_d;
  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [7:0]            scan_code_q, scan_code_d;
  logic                  scan_ready_q, scan_ready_d;
  logic                  frame_err_q, frame_err_d;

  logic sample;
  logic data_bit;

  // Synchroniser and clock filter
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_clk_d  = filt_clk_q;
    if (&filt_sr_q) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_sr_q) begin
      filt_clk_d = 1'b0;
    end
    sample   = filt_clk_q & ~filt_clk_d;
    data_bit = data_sync_q[1];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = to_cnt_q;
    scan_code_d  = scan_code_q;
    scan_ready_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (sample && !data_bit) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          parity_d = data_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (data_bit && (^{shift_q, parity_q})) begin
            scan_code_d  = shift_q;
            scan_ready_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A sample event always wins over a coincident timeout expiry
    if (state_q != IDLE) begin
      if (sample) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d    = '0;
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      filt_sr_q    <= '1;
      filt_clk_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      scan_code_q  <= '0;
      scan_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_sr_q    <= filt_sr_d;
      filt_clk_q   <= filt_clk_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_ready_q <= scan_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_ready = scan_ready_q;
  assign frame_err  = frame_err_q;

endmodule
